// File: rtl/serial_transfer_unit.sv
// Captures one memory word and shifts it out serially, then pulses TransferDone.
// Optional even-parity trailer bit when the PARITY_EN macro is defined.
module serial_transfer_unit #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  SampleData,
  input  logic                  TransferData,
  input  logic                  Mode,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic                  DataOut,
  output logic                  OutValid,
  output logic                  Busy,
  output logic                  TransferDone
);

`ifdef PARITY_EN
  localparam int unsigned NBITS = DATA_WIDTH + 1;
`else
  localparam int unsigned NBITS = DATA_WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} state_t;

  state_t                state, stateNext;
  logic [DATA_WIDTH-1:0] shiftReg, shiftNext;
  logic                  modeReg, modeNext;
  logic [CNT_W-1:0]      bitCnt, bitCntNext;
  logic                  dataOutNext, outValidNext, busyNext, doneNext;
`ifdef PARITY_EN
  logic                  parityReg, parityNext;
`endif

  // State, datapath and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      shiftReg     <= '0;
      modeReg      <= 1'b0;
      bitCnt       <= '0;
      DataOut      <= 1'b0;
      OutValid     <= 1'b0;
      Busy         <= 1'b0;
      TransferDone <= 1'b0;
`ifdef PARITY_EN
      parityReg    <= 1'b0;
`endif
    end else begin
      state        <= stateNext;
      shiftReg     <= shiftNext;
      modeReg      <= modeNext;
      bitCnt       <= bitCntNext;
      DataOut      <= dataOutNext;
      OutValid     <= outValidNext;
      Busy         <= busyNext;
      TransferDone <= doneNext;
`ifdef PARITY_EN
      parityReg    <= parityNext;
`endif
    end
  end

  // Next state and next output values; outputs lag the state by one edge
  always_comb begin
    stateNext    = state;
    shiftNext    = shiftReg;
    modeNext     = modeReg;
    bitCntNext   = bitCnt;
    dataOutNext  = 1'b0;
    outValidNext = 1'b0;
    busyNext     = 1'b0;
    doneNext     = 1'b0;
`ifdef PARITY_EN
    parityNext   = parityReg;
`endif

    case (state)
      IDLE: begin
        if (SampleData) begin
          shiftNext = DataIn;
          modeNext  = Mode;
`ifdef PARITY_EN
          parityNext = ^DataIn;
`endif
          stateNext = LOADED;
        end
      end

      LOADED: begin
        // A fresh capture wins over a start request in the same cycle
        if (SampleData) begin
          shiftNext = DataIn;
          modeNext  = Mode;
`ifdef PARITY_EN
          parityNext = ^DataIn;
`endif
        end else if (TransferData) begin
          bitCntNext = '0;
          stateNext  = SHIFT;
        end
      end

      SHIFT: begin
        busyNext     = 1'b1;
        outValidNext = 1'b1;
        if (modeReg) begin
          dataOutNext = shiftReg[DATA_WIDTH-1];
          shiftNext   = {shiftReg[DATA_WIDTH-2:0], 1'b0};
        end else begin
          dataOutNext = shiftReg[0];
          shiftNext   = {1'b0, shiftReg[DATA_WIDTH-1:1]};
        end
`ifdef PARITY_EN
        if (bitCnt == CNT_W'(DATA_WIDTH)) dataOutNext = parityReg;
`endif
        if (bitCnt == LAST_BIT) begin
          bitCntNext = '0;
          stateNext  = DONE;
        end else begin
          bitCntNext = bitCnt + CNT_W'(1);
        end
      end

      DONE: begin
        busyNext = 1'b1;
        doneNext = 1'b1;
        if (SampleData) begin
          shiftNext = DataIn;
          modeNext  = Mode;
`ifdef PARITY_EN
          parityNext = ^DataIn;
`endif
          stateNext = LOADED;
        end else begin
          // Word is spent; a new capture is needed before the next transfer
          shiftNext = '0;
          stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_transfer_unit.sv
// Directed self-checking bench for serial_transfer_unit (default DATA_WIDTH = 8).
module tb_serial_transfer_unit;

  logic       Clk;
  logic       Reset;
  logic       SampleData;
  logic       TransferData;
  logic       Mode;
  logic [7:0] DataIn;
  logic       DataOut;
  logic       OutValid;
  logic       Busy;
  logic       TransferDone;

  int checks = 0;
  int errors = 0;

  serial_transfer_unit #(.DATA_WIDTH(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .SampleData   (SampleData),
    .TransferData (TransferData),
    .Mode         (Mode),
    .DataIn       (DataIn),
    .DataOut      (DataOut),
    .OutValid     (OutValid),
    .Busy         (Busy),
    .TransferDone (TransferDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle before sampling or driving
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Capture a word for one cycle, then request the transfer for one cycle
  task automatic load_and_start(input logic [7:0] data, input logic mode);
    DataIn = data; Mode = mode; SampleData = 1'b1; TransferData = 1'b0;
    tick();
    SampleData = 1'b0; TransferData = 1'b1;
    tick();
    TransferData = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; SampleData = 1'b0; TransferData = 1'b0; Mode = 1'b0; DataIn = 8'h00;
    tick(); tick();
    Reset = 1'b0;
    checks++;
    if ({DataOut, OutValid, Busy, TransferDone} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {DataOut, OutValid, Busy, TransferDone});
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] seq;
    int busyCycles;
    seq = 8'b0001_1110;  // first bit in [7]
    busyCycles = 0;
    load_and_start(8'h1E, 1'b1);
    checks++;
    if (OutValid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL msb_latency: OutValid=%b Busy=%b expected 0 0 right after start edge", OutValid, Busy);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (Busy === 1'b1) busyCycles++;
      checks++;
      if (OutValid !== 1'b1 || DataOut !== seq[7-i] || TransferDone !== 1'b0) begin
        errors++;
        $display("FAIL msb_bit%0d: valid=%b data=%b done=%b expected 1 %b 0", i, OutValid, DataOut, TransferDone, seq[7-i]);
      end
    end
`ifdef PARITY_EN
    tick();
    if (Busy === 1'b1) busyCycles++;
    checks++;
    if (OutValid !== 1'b1 || DataOut !== 1'b0) begin
      errors++;
      $display("FAIL msb_parity: valid=%b data=%b expected 1 0", OutValid, DataOut);
    end
`endif
    tick();
    if (Busy === 1'b1) busyCycles++;
    checks++;
    if (TransferDone !== 1'b1 || OutValid !== 1'b0 || DataOut !== 1'b0) begin
      errors++;
      $display("FAIL msb_done: done=%b valid=%b data=%b expected 1 0 0", TransferDone, OutValid, DataOut);
    end
    tick();
    checks++;
    if (TransferDone !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL msb_done_width: done=%b busy=%b expected 0 0", TransferDone, Busy);
    end
    checks++;
`ifdef PARITY_EN
    if (busyCycles != 10) begin
      errors++;
      $display("FAIL msb_busy_cycles: got %0d expected 10", busyCycles);
    end
`else
    if (busyCycles != 9) begin
      errors++;
      $display("FAIL msb_busy_cycles: got %0d expected 9", busyCycles);
    end
`endif
  endtask

  task automatic test_lsb_first();
    logic [7:0] seq;
    seq = 8'b0111_1000;  // first bit in [7]
    // Capture a word, overwrite it; a start in the same cycle as the overwrite is ignored
    DataIn = 8'hFF; Mode = 1'b1; SampleData = 1'b1;
    tick();
    DataIn = 8'h1E; Mode = 1'b0; TransferData = 1'b1;
    tick();
    SampleData = 1'b0; TransferData = 1'b0;
    tick();
    checks++;
    if (OutValid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL lsb_sample_priority: valid=%b busy=%b expected 0 0", OutValid, Busy);
    end
    TransferData = 1'b1;
    tick();
    TransferData = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (OutValid !== 1'b1 || DataOut !== seq[7-i]) begin
        errors++;
        $display("FAIL lsb_bit%0d: valid=%b data=%b expected 1 %b", i, OutValid, DataOut, seq[7-i]);
      end
    end
`ifdef PARITY_EN
    tick();
`endif
    tick();
    checks++;
    if (TransferDone !== 1'b1 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL lsb_done: done=%b valid=%b expected 1 0", TransferDone, OutValid);
    end
  endtask

  task automatic test_transfer_without_sample();
    tick();
    TransferData = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({OutValid, Busy, TransferDone} !== 3'b000) begin
        errors++;
        $display("FAIL idle_ignore_c%0d: valid/busy/done=%b expected 000", i, {OutValid, Busy, TransferDone});
      end
    end
    TransferData = 1'b0;
    // Run a full transfer, then request another right after the done pulse
    load_and_start(8'h5A, 1'b1);
    for (int i = 0; i < 8; i++) tick();
`ifdef PARITY_EN
    tick();
`endif
    tick();
    checks++;
    if (TransferDone !== 1'b1) begin
      errors++;
      $display("FAIL after_done_pulse: done=%b expected 1", TransferDone);
    end
    TransferData = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({OutValid, Busy, TransferDone} !== 3'b000) begin
        errors++;
        $display("FAIL after_done_ignore_c%0d: valid/busy/done=%b expected 000", i, {OutValid, Busy, TransferDone});
      end
    end
    TransferData = 1'b0;
  endtask

  task automatic test_midshift_sample();
    logic [7:0] seq;
    seq = 8'b0001_1110;
    load_and_start(8'h1E, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (OutValid !== 1'b1 || DataOut !== seq[7-i]) begin
        errors++;
        $display("FAIL midshift_bit%0d: valid=%b data=%b expected 1 %b", i, OutValid, DataOut, seq[7-i]);
      end
      if (i == 3) begin
        SampleData = 1'b1; DataIn = 8'hFF; Mode = 1'b0;
      end else if (i == 4) begin
        SampleData = 1'b0;
      end
    end
`ifdef PARITY_EN
    tick();
`endif
    tick();
    checks++;
    if (TransferDone !== 1'b1) begin
      errors++;
      $display("FAIL midshift_done: done=%b expected 1", TransferDone);
    end
    Mode = 1'b1;
  endtask

  task automatic test_reset_midshift();
    load_and_start(8'h1E, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (OutValid !== 1'b1 || DataOut !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_bit4: valid=%b data=%b expected 1 1", OutValid, DataOut);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if ({DataOut, OutValid, Busy, TransferDone} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b expected 0000", {DataOut, OutValid, Busy, TransferDone});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({OutValid, Busy, TransferDone} !== 3'b000) begin
        errors++;
        $display("FAIL rst_mid_quiet_c%0d: valid/busy/done=%b expected 000", i, {OutValid, Busy, TransferDone});
      end
    end
    TransferData = 1'b1;
    tick();
    TransferData = 1'b0;
    tick();
    checks++;
    if ({OutValid, Busy, TransferDone} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_no_word: valid/busy/done=%b expected 000", {OutValid, Busy, TransferDone});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    seq = 8'b1010_0101;  // 8'hA5 MSB first
    load_and_start(8'h3C, 1'b0);
    for (int i = 0; i < 8; i++) tick();
`ifdef PARITY_EN
    tick();
`endif
    // State is DONE now; capture the next word in the same cycle
    SampleData = 1'b1; DataIn = 8'hA5; Mode = 1'b1;
    tick();
    SampleData = 1'b0;
    checks++;
    if (TransferDone !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_pulse: done=%b expected 1", TransferDone);
    end
    TransferData = 1'b1;
    tick();
    TransferData = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (OutValid !== 1'b1 || DataOut !== seq[7-i]) begin
        errors++;
        $display("FAIL b2b_bit%0d: valid=%b data=%b expected 1 %b", i, OutValid, DataOut, seq[7-i]);
      end
    end
`ifdef PARITY_EN
    tick();
`endif
    tick();
    checks++;
    if (TransferDone !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done: done=%b expected 1", TransferDone);
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [8:0] seq;
    seq = 9'b0_0000_1111;  // 8'h07 then parity 1
    load_and_start(8'h07, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (OutValid !== 1'b1 || DataOut !== seq[8-i]) begin
        errors++;
        $display("FAIL parity07_bit%0d: valid=%b data=%b expected 1 %b", i, OutValid, DataOut, seq[8-i]);
      end
    end
    tick();
    checks++;
    if (TransferDone !== 1'b1 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL parity07_done: done=%b valid=%b expected 1 0", TransferDone, OutValid);
    end
    load_and_start(8'h1E, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (OutValid !== 1'b1 || DataOut !== 1'b0) begin
      errors++;
      $display("FAIL parity1e_bit8: valid=%b data=%b expected 1 0", OutValid, DataOut);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_transfer_without_sample();
    test_midshift_sample();
    test_reset_midshift();
    test_back_to_back();
`ifdef PARITY_EN
    test_parity();
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
